// File: rtl/mem_req_master_if.sv
// Command/response link between the cartridge-bus mux logic and the DDR3 memory wrapper.
interface mux_mem_interface #(
   parameter int unsigned ADDR_WIDTH = 26,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  mem_rd;
   logic                  mem_wr;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [1:0]            mem_data_width;
   logic [DATA_WIDTH-1:0] mem_wr_data;
   logic                  mem_rd_ready;
   logic                  mem_wr_ready;
   logic [DATA_WIDTH-1:0] mem_rd_data;
   logic                  mem_rd_valid;

   modport mux (
      output mem_rd, mem_wr, mem_addr, mem_data_width, mem_wr_data,
      input  mem_rd_ready, mem_wr_ready, mem_rd_data, mem_rd_valid
   );

   modport mem (
      input  mem_rd, mem_wr, mem_addr, mem_data_width, mem_wr_data,
      output mem_rd_ready, mem_wr_ready, mem_rd_data, mem_rd_valid
   );
endinterface

// File: rtl/mem_req_master.sv
// Initiator side of mux_mem_interface: holds one command until accepted, tracks in-flight reads and
// returns zero-extended read data in order. Optional counters: define MEM_REQ_MASTER_STATS_EN.
module mem_req_master #(
   parameter int unsigned ADDR_WIDTH = 26,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned RSP_DEPTH  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic                          req_wr,
   input  logic [ADDR_WIDTH-1:0]         req_addr,
   input  logic [1:0]                    req_width,
   input  logic [DATA_WIDTH-1:0]         req_wdata,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   output logic                          err,
`ifdef MEM_REQ_MASTER_STATS_EN
   output logic [31:0]                   rd_cnt,
   output logic [31:0]                   wr_cnt,
   output logic [$clog2(RSP_DEPTH):0]    pend_max,
`endif
   mux_mem_interface.mux                 mux_mem
);
   localparam int unsigned PW = $clog2(RSP_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW:0]   DEPTH_C = (CW + 1)'(RSP_DEPTH);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   logic                  cmd_valid_q, cmd_valid_d, cmd_wr_q, cmd_wr_d;
   logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
   logic [1:0]            cmd_width_q, cmd_width_d;
   logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
   logic [CW-1:0]         pend_q, pend_d, cnt_q, cnt_d;
   logic [1:0]            wq_q [RSP_DEPTH];
   logic [1:0]            wq_d [RSP_DEPTH];
   logic [PW-1:0]         wq_wptr_q, wq_wptr_d, wq_rptr_q, wq_rptr_d;
   logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_d [RSP_DEPTH];
   logic [PW-1:0]         f_wptr_q, f_wptr_d, f_rptr_q, f_rptr_d;
   logic                  err_q, err_d;
   logic                  credit, wr_fire, rd_fire, rd_ret, pop;

   function automatic logic [DATA_WIDTH-1:0] ext(input logic [1:0] w,
                                                 input logic [DATA_WIDTH-1:0] d);
      logic [DATA_WIDTH-1:0] r;
      r = '0;
      case (w)
         2'b01:   r[7:0]  = d[7:0];
         2'b10:   r[15:0] = d[15:0];
         2'b11:   r       = d;
         default: r       = '0;
      endcase
      return r;
   endfunction

   // Credit counts both in-flight reads and buffered responses, so the FIFO can never overflow.
   assign credit    = ({1'b0, pend_q} + {1'b0, cnt_q}) < DEPTH_C;
   assign req_ready = ~cmd_valid_q;
   assign rsp_valid = (cnt_q != '0);
   assign rsp_data  = rsp_valid ? fifo_q[f_rptr_q] : '0;
   assign err       = err_q;
   assign pop       = rsp_valid & rsp_ready;

   assign mux_mem.mem_wr         = cmd_valid_q & cmd_wr_q;
   assign mux_mem.mem_rd         = cmd_valid_q & ~cmd_wr_q & credit;
   assign mux_mem.mem_addr       = cmd_addr_q;
   assign mux_mem.mem_data_width = cmd_width_q;
   assign mux_mem.mem_wr_data    = cmd_wdata_q;

   assign wr_fire = cmd_valid_q & cmd_wr_q & mux_mem.mem_wr_ready;
   assign rd_fire = cmd_valid_q & ~cmd_wr_q & credit & mux_mem.mem_rd_ready;
   assign rd_ret  = mux_mem.mem_rd_valid & (pend_q != '0);

   always_comb begin
      cmd_valid_d = cmd_valid_q;
      cmd_wr_d    = cmd_wr_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_width_d = cmd_width_q;
      cmd_wdata_d = cmd_wdata_q;
      pend_d      = pend_q;
      cnt_d       = cnt_q;
      wq_d        = wq_q;
      wq_wptr_d   = wq_wptr_q;
      wq_rptr_d   = wq_rptr_q;
      fifo_d      = fifo_q;
      f_wptr_d    = f_wptr_q;
      f_rptr_d    = f_rptr_q;
      err_d       = err_q | (mux_mem.mem_rd_valid & (pend_q == '0));

      if (wr_fire || rd_fire) cmd_valid_d = 1'b0;
      if (req_valid && req_ready) begin
         cmd_valid_d = 1'b1;
         cmd_wr_d    = req_wr;
         cmd_addr_d  = req_addr;
         cmd_width_d = req_width;
         cmd_wdata_d = req_wdata;
      end

      if (rd_fire) begin
         wq_d[wq_wptr_q] = cmd_width_q;
         wq_wptr_d       = wq_wptr_q + PTR_ONE;
      end
      if (rd_ret) begin
         wq_rptr_d        = wq_rptr_q + PTR_ONE;
         fifo_d[f_wptr_q] = ext(wq_q[wq_rptr_q], mux_mem.mem_rd_data);
         f_wptr_d         = f_wptr_q + PTR_ONE;
      end
      if (pop) f_rptr_d = f_rptr_q + PTR_ONE;

      case ({rd_fire, rd_ret})
         2'b10:   pend_d = pend_q + CNT_ONE;
         2'b01:   pend_d = pend_q - CNT_ONE;
         default: pend_d = pend_q;
      endcase
      case ({rd_ret, pop})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cmd_valid_q <= 1'b0;
         cmd_wr_q    <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_width_q <= '0;
         cmd_wdata_q <= '0;
         pend_q      <= '0;
         cnt_q       <= '0;
         wq_q        <= '{default: '0};
         wq_wptr_q   <= '0;
         wq_rptr_q   <= '0;
         fifo_q      <= '{default: '0};
         f_wptr_q    <= '0;
         f_rptr_q    <= '0;
         err_q       <= 1'b0;
      end else begin
         cmd_valid_q <= cmd_valid_d;
         cmd_wr_q    <= cmd_wr_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_width_q <= cmd_width_d;
         cmd_wdata_q <= cmd_wdata_d;
         pend_q      <= pend_d;
         cnt_q       <= cnt_d;
         wq_q        <= wq_d;
         wq_wptr_q   <= wq_wptr_d;
         wq_rptr_q   <= wq_rptr_d;
         fifo_q      <= fifo_d;
         f_wptr_q    <= f_wptr_d;
         f_rptr_q    <= f_rptr_d;
         err_q       <= err_d;
      end
   end

`ifdef MEM_REQ_MASTER_STATS_EN
   logic [31:0]   rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
   logic [CW-1:0] pend_max_q, pend_max_d;

   always_comb begin
      rd_cnt_d   = rd_fire ? rd_cnt_q + 32'd1 : rd_cnt_q;
      wr_cnt_d   = wr_fire ? wr_cnt_q + 32'd1 : wr_cnt_q;
      pend_max_d = (pend_q > pend_max_q) ? pend_q : pend_max_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_cnt_q   <= '0;
         wr_cnt_q   <= '0;
         pend_max_q <= '0;
      end else begin
         rd_cnt_q   <= rd_cnt_d;
         wr_cnt_q   <= wr_cnt_d;
         pend_max_q <= pend_max_d;
      end
   end

   assign rd_cnt   = rd_cnt_q;
   assign wr_cnt   = wr_cnt_q;
   assign pend_max = pend_max_q;
`endif
endmodule
